// File: rtl/avs_bank_router.sv
// rtl/avs_bank_router.sv - one Avalon-MM master routed onto NUM_BANKS banks with in-order read return (optional AVS_ROUTER_PERF_EN perf counters)
module avs_bank_router #(
    parameter int NUM_BANKS       = 2,
    parameter int BANK_ADDR_WIDTH = 26,
    parameter int DATA_WIDTH      = 512,
    parameter int BURST_WIDTH     = 7,
    parameter int RSP_DEPTH       = 64,
    parameter int ORDQ_DEPTH      = 16,
    parameter int INTERLEAVE      = 1,
    localparam int SW             = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [BANK_ADDR_WIDTH+SW-1:0]          req_address,
    input  logic                                   req_read,
    input  logic                                   req_write,
    input  logic [DATA_WIDTH-1:0]                  req_writedata,
    input  logic [DATA_WIDTH/8-1:0]                req_byteenable,
    input  logic [BURST_WIDTH-1:0]                 req_burstcount,
    output logic                                   req_waitrequest,
    output logic [DATA_WIDTH-1:0]                  rsp_readdata,
    output logic                                   rsp_readdatavalid,
    output logic [NUM_BANKS*BANK_ADDR_WIDTH-1:0]   avs_address,
    output logic [NUM_BANKS-1:0]                   avs_read,
    output logic [NUM_BANKS-1:0]                   avs_write,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]        avs_writedata,
    output logic [NUM_BANKS*DATA_WIDTH/8-1:0]      avs_byteenable,
    output logic [NUM_BANKS*BURST_WIDTH-1:0]       avs_burstcount,
    input  logic [NUM_BANKS-1:0]                   avs_waitrequest,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0]        avs_readdata,
    input  logic [NUM_BANKS-1:0]                   avs_readdatavalid
`ifdef AVS_ROUTER_PERF_EN
    ,
    output logic [31:0]                            perf_reads,
    output logic [31:0]                            perf_writes,
    output logic [31:0]                            perf_stalls
`endif
);

    localparam int AW   = BANK_ADDR_WIDTH + SW;
    localparam int PW   = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW   = $clog2(RSP_DEPTH + 1);
    localparam int QW   = (ORDQ_DEPTH > 1) ? $clog2(ORDQ_DEPTH) : 1;
    localparam int QCW  = $clog2(ORDQ_DEPTH + 1);
    localparam int SUMW = ((CW > BURST_WIDTH) ? CW : BURST_WIDTH) + 1;

    typedef enum logic {IDLE, WR_BURST} wstate_t;

    wstate_t                state, state_next;
    logic [SW-1:0]          wr_bank, wr_bank_next;
    logic [BURST_WIDTH-1:0] beats_left, beats_left_next;

    logic [SW-1:0]              addr_bank;
    logic [SW-1:0]              sel_bank;
    logic [BANK_ADDR_WIDTH-1:0] bank_addr;
    logic [SUMW-1:0]            credit_sum;
    logic                       credit_fail;
    logic                       ordq_full;
    logic                       read_block;
    logic                       block;
    logic                       read_acc;
    logic                       write_acc;

    // per-bank response FIFOs and credit counters
    logic [DATA_WIDTH-1:0] fifo_mem [NUM_BANKS][RSP_DEPTH];
    logic [PW-1:0]         fifo_rptr [NUM_BANKS];
    logic [PW-1:0]         fifo_wptr [NUM_BANKS];
    logic [CW-1:0]         fifo_count [NUM_BANKS];
    logic [CW-1:0]         outstanding [NUM_BANKS];
    logic [NUM_BANKS-1:0]  fifo_push;
    logic [NUM_BANKS-1:0]  fifo_pop;

    // ordering queue of accepted reads
    logic [SW-1:0]          oq_bank [ORDQ_DEPTH];
    logic [BURST_WIDTH-1:0] oq_burst [ORDQ_DEPTH];
    logic [QW-1:0]          oq_rptr, oq_wptr;
    logic [QCW-1:0]         oq_count;
    logic [BURST_WIDTH-1:0] beat_cnt;
    logic [SW-1:0]          head_bank;
    logic [BURST_WIDTH-1:0] head_burst;
    logic                   pop_beat;
    logic                   last_beat;

    function automatic logic [PW-1:0] fifo_next(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [QW-1:0] oq_next(input logic [QW-1:0] p);
        return (p == QW'(ORDQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign addr_bank = (NUM_BANKS == 1) ? '0 :
                       ((INTERLEAVE != 0) ? req_address[SW-1:0] : req_address[AW-1:BANK_ADDR_WIDTH]);
    assign bank_addr = (INTERLEAVE != 0) ? req_address[AW-1:SW] : req_address[BANK_ADDR_WIDTH-1:0];
    // a write burst stays on the bank of its first beat
    assign sel_bank  = (state == WR_BURST) ? wr_bank : addr_bank;

    // outstanding counts include beats already buffered, so the FIFO can never overflow
    assign credit_sum  = SUMW'(outstanding[addr_bank]) + SUMW'(req_burstcount);
    assign credit_fail = credit_sum > SUMW'(RSP_DEPTH);
    assign ordq_full   = (oq_count == QCW'(ORDQ_DEPTH));
    assign read_block  = ordq_full | credit_fail | (state == WR_BURST);
    assign block       = !reset_n | (req_read & read_block);

    assign req_waitrequest = avs_waitrequest[sel_bank] | block;
    assign read_acc        = req_read  & !req_waitrequest;
    assign write_acc       = req_write & !req_waitrequest;

    assign avs_address    = {NUM_BANKS{bank_addr}};
    assign avs_writedata  = {NUM_BANKS{req_writedata}};
    assign avs_byteenable = {NUM_BANKS{req_byteenable}};
    assign avs_burstcount = {NUM_BANKS{req_burstcount}};

    // steer read/write strobes to the selected bank only
    always_comb begin
        avs_read  = '0;
        avs_write = '0;
        if (!block) begin
            avs_read[sel_bank]  = req_read;
            avs_write[sel_bank] = req_write;
        end
    end

    // write-burst tracking: next state, latched bank and remaining beats
    always_comb begin
        state_next      = state;
        wr_bank_next    = wr_bank;
        beats_left_next = beats_left;
        case (state)
            IDLE: begin
                if (write_acc && (req_burstcount > BURST_WIDTH'(1))) begin
                    state_next      = WR_BURST;
                    wr_bank_next    = addr_bank;
                    beats_left_next = req_burstcount - 1'b1;
                end
            end
            WR_BURST: begin
                if (write_acc) begin
                    if (beats_left == BURST_WIDTH'(1)) begin
                        state_next = IDLE;
                    end
                    beats_left_next = beats_left - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign head_bank  = oq_bank[oq_rptr];
    assign head_burst = oq_burst[oq_rptr];
    assign pop_beat   = (oq_count != '0) && (fifo_count[head_bank] != '0);
    assign last_beat  = pop_beat && (beat_cnt == head_burst - 1'b1);

    // accept bank beats only while that bank still owes data; late beats from before a reset are dropped
    always_comb begin
        fifo_push = '0;
        fifo_pop  = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            fifo_push[b] = avs_readdatavalid[b] && (fifo_count[b] < outstanding[b]);
            fifo_pop[b]  = pop_beat && (head_bank == SW'(b));
        end
    end

    // response FIFO and ordering queue storage (no reset needed, pointers qualify contents)
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (fifo_push[b]) begin
                fifo_mem[b][fifo_wptr[b]] <= avs_readdata[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        if (read_acc) begin
            oq_bank[oq_wptr]  <= addr_bank;
            oq_burst[oq_wptr] <= req_burstcount;
        end
    end

    // control state, queue pointers, credit counters and registered response output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            wr_bank           <= '0;
            beats_left        <= '0;
            oq_rptr           <= '0;
            oq_wptr           <= '0;
            oq_count          <= '0;
            beat_cnt          <= '0;
            rsp_readdatavalid <= 1'b0;
            rsp_readdata      <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                fifo_rptr[b]   <= '0;
                fifo_wptr[b]   <= '0;
                fifo_count[b]  <= '0;
                outstanding[b] <= '0;
            end
        end else begin
            state      <= state_next;
            wr_bank    <= wr_bank_next;
            beats_left <= beats_left_next;
            if (read_acc) begin
                oq_wptr <= oq_next(oq_wptr);
            end
            if (last_beat) begin
                oq_rptr <= oq_next(oq_rptr);
            end
            oq_count <= oq_count + QCW'(read_acc) - QCW'(last_beat);
            if (last_beat) begin
                beat_cnt <= '0;
            end else if (pop_beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            rsp_readdatavalid <= pop_beat;
            if (pop_beat) begin
                rsp_readdata <= fifo_mem[head_bank][fifo_rptr[head_bank]];
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (fifo_push[b]) begin
                    fifo_wptr[b] <= fifo_next(fifo_wptr[b]);
                end
                if (fifo_pop[b]) begin
                    fifo_rptr[b] <= fifo_next(fifo_rptr[b]);
                end
                fifo_count[b]  <= fifo_count[b] + CW'(fifo_push[b]) - CW'(fifo_pop[b]);
                outstanding[b] <= outstanding[b]
                                  + ((read_acc && (addr_bank == SW'(b))) ? CW'(req_burstcount) : CW'(0))
                                  - CW'(fifo_pop[b]);
            end
        end
    end

`ifdef AVS_ROUTER_PERF_EN
    // saturating activity counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_reads  <= '0;
            perf_writes <= '0;
            perf_stalls <= '0;
        end else begin
            if (read_acc && (perf_reads != '1)) begin
                perf_reads <= perf_reads + 1'b1;
            end
            if (write_acc && (perf_writes != '1)) begin
                perf_writes <= perf_writes + 1'b1;
            end
            if ((req_read | req_write) && req_waitrequest && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_avs_bank_router.sv
// tb/tb_avs_bank_router.sv - scoreboard bench for avs_bank_router
module tb_avs_bank_router;

    localparam int NB  = 2;
    localparam int BAW = 8;
    localparam int DW  = 32;
    localparam int BW  = 4;

    logic                 clk;
    logic                 reset_n;
    logic [BAW:0]         req_address;
    logic                 req_read;
    logic                 req_write;
    logic [DW-1:0]        req_writedata;
    logic [DW/8-1:0]      req_byteenable;
    logic [BW-1:0]        req_burstcount;
    logic                 req_waitrequest;
    logic [DW-1:0]        rsp_readdata;
    logic                 rsp_readdatavalid;
    logic [NB*BAW-1:0]    avs_address;
    logic [NB-1:0]        avs_read;
    logic [NB-1:0]        avs_write;
    logic [NB*DW-1:0]     avs_writedata;
    logic [NB*DW/8-1:0]   avs_byteenable;
    logic [NB*BW-1:0]     avs_burstcount;
    logic [NB-1:0]        avs_waitrequest;
    logic [NB*DW-1:0]     avs_readdata;
    logic [NB-1:0]        avs_readdatavalid;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] sb [$];
    logic [DW-1:0] mon_exp;

    avs_bank_router #(
        .NUM_BANKS(NB), .BANK_ADDR_WIDTH(BAW), .DATA_WIDTH(DW), .BURST_WIDTH(BW),
        .RSP_DEPTH(8), .ORDQ_DEPTH(16), .INTERLEAVE(1)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_address(req_address), .req_read(req_read), .req_write(req_write),
        .req_writedata(req_writedata), .req_byteenable(req_byteenable),
        .req_burstcount(req_burstcount), .req_waitrequest(req_waitrequest),
        .rsp_readdata(rsp_readdata), .rsp_readdatavalid(rsp_readdatavalid),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
        .avs_burstcount(avs_burstcount), .avs_waitrequest(avs_waitrequest),
        .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every upstream beat must match the oldest expected entry
    always @(negedge clk) begin
        if (reset_n && rsp_readdatavalid) begin
            if (sb.size() != 0) mon_exp = sb.pop_front();
            else mon_exp = 'x;
            check("rsp_data", {32'h0, rsp_readdata}, {32'h0, mon_exp});
        end
    end

    task automatic issue_read(input logic [BAW:0] a, input logic [BW-1:0] bc, input string tag);
        logic acc;
        acc = 1'b0;
        req_read = 1'b1;
        req_address = a;
        req_burstcount = bc;
        for (int i = 0; i < 40 && !acc; i++) begin
            #1;
            acc = !req_waitrequest;
            @(negedge clk);
        end
        req_read = 1'b0;
        check(tag, {63'h0, acc}, 64'h1);
    endtask

    task automatic do_write(input logic [BAW:0] a, input logic [BW-1:0] bc, input logic [DW-1:0] d,
                            input logic [NB-1:0] exp_mask, input string tag);
        req_write = 1'b1;
        req_address = a;
        req_burstcount = bc;
        req_writedata = d;
        #1;
        check({tag, "_mask"}, {62'h0, avs_write}, {62'h0, exp_mask});
        check({tag, "_wdata"}, {32'h0, avs_writedata[2*DW-1:DW]}, {32'h0, d});
        @(negedge clk);
        req_write = 1'b0;
    endtask

    task automatic bank_beat(input int b, input logic [DW-1:0] d);
        avs_readdatavalid = '0;
        avs_readdatavalid[b] = 1'b1;
        avs_readdata[b*DW +: DW] = d;
        @(negedge clk);
        avs_readdatavalid = '0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check(tag, 64'(sb.size()), 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        req_address = '0; req_read = 1'b0; req_write = 1'b0;
        req_writedata = '0; req_byteenable = '1; req_burstcount = 4'd1;
        avs_waitrequest = '0; avs_readdata = '0; avs_readdatavalid = '0;
        #1;
        check("rst_rvalid", {63'h0, rsp_readdatavalid}, 64'h0);
        check("rst_wait", {63'h0, req_waitrequest}, 64'h1);
        check("rst_avs_rd", {62'h0, avs_read}, 64'h0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // single read, interleaved decode: addr 5 -> bank 1, bank address 2
        req_read = 1'b1; req_address = 9'h005; req_burstcount = 4'd1;
        #1;
        check("t1_avs_read", {62'h0, avs_read}, 64'h2);
        check("t1_bank_addr", {56'h0, avs_address[2*BAW-1:BAW]}, 64'h2);
        check("t1_wait", {63'h0, req_waitrequest}, 64'h0);
        sb.push_back(32'hAB);
        @(negedge clk);
        req_read = 1'b0;
        bank_beat(1, 32'hAB);
        check("t1_lat_n", {63'h0, rsp_readdatavalid}, 64'h0);
        @(negedge clk);
        check("t1_lat_n1", {63'h0, rsp_readdatavalid}, 64'h1);
        check("t1_data", {32'h0, rsp_readdata}, 64'hAB);
        drain("t1_drain");

        // reorder: bank 1 answers before bank 0
        sb.push_back(32'h11); issue_read(9'h000, 4'd1, "t2_rd0");
        sb.push_back(32'h22); issue_read(9'h001, 4'd1, "t2_rd1");
        bank_beat(1, 32'h22);
        @(negedge clk);
        check("t2_hold", {63'h0, rsp_readdatavalid}, 64'h0);
        bank_beat(0, 32'h11);
        drain("t2_drain");

        // write burst of 4 pinned to bank 1, read held mid-burst
        do_write(9'h001, 4'd4, 32'hA0, 2'b10, "t3_b0");
        do_write(9'h002, 4'd4, 32'hA1, 2'b10, "t3_b1");
        req_read = 1'b1; req_address = 9'h000; req_burstcount = 4'd1;
        #1;
        check("t3_rd_wait", {63'h0, req_waitrequest}, 64'h1);
        check("t3_rd_avs", {62'h0, avs_read}, 64'h0);
        @(negedge clk);
        req_read = 1'b0;
        do_write(9'h004, 4'd4, 32'hA2, 2'b10, "t3_b2");
        do_write(9'h006, 4'd4, 32'hA3, 2'b10, "t3_b3");
        do_write(9'h000, 4'd1, 32'hA4, 2'b01, "t3_idle");
        sb.push_back(32'h33); issue_read(9'h000, 4'd1, "t3_rd_after");
        bank_beat(0, 32'h33);
        drain("t3_drain");

        // credit limit: 8 beats outstanding on bank 0 block a further read
        for (int i = 0; i < 4; i++) sb.push_back(32'h100 + i);
        issue_read(9'h000, 4'd4, "t4_rd0");
        for (int i = 4; i < 8; i++) sb.push_back(32'h100 + i);
        issue_read(9'h002, 4'd4, "t4_rd1");
        req_read = 1'b1; req_address = 9'h004; req_burstcount = 4'd1;
        #1;
        check("t4_blocked", {63'h0, req_waitrequest}, 64'h1);
        @(negedge clk);
        bank_beat(0, 32'h100);
        check("t4_still_blocked", {63'h0, req_waitrequest}, 64'h1);
        for (int i = 0; i < 10 && req_waitrequest; i++) @(negedge clk);
        check("t4_released", {63'h0, req_waitrequest}, 64'h0);
        sb.push_back(32'h108);
        @(negedge clk);
        req_read = 1'b0;
        for (int i = 1; i < 9; i++) bank_beat(0, 32'h100 + i);
        drain("t4_drain");

        // ordering queue full: 16 reads in flight, 17th held
        for (int i = 0; i < 16; i++) begin
            sb.push_back(32'h200 + i);
            issue_read(9'(i), 4'd1, $sformatf("t5_rd%0d", i));
        end
        req_read = 1'b1; req_address = 9'h010; req_burstcount = 4'd1;
        #1;
        check("t5_17th_wait", {63'h0, req_waitrequest}, 64'h1);
        @(negedge clk); @(negedge clk);
        check("t5_17th_hold", {63'h0, req_waitrequest}, 64'h1);
        req_read = 1'b0;
        for (int i = 1; i < 16; i += 2) bank_beat(1, 32'h200 + i);
        for (int i = 0; i < 16; i += 2) bank_beat(0, 32'h200 + i);
        drain("t5_drain");

        // reset mid-burst with a read outstanding
        sb.push_back(32'h41); sb.push_back(32'h42);
        issue_read(9'h001, 4'd2, "t6_rd");
        bank_beat(1, 32'h41);
        @(negedge clk); @(negedge clk);
        do_write(9'h000, 4'd4, 32'hB0, 2'b01, "t6_b0");
        do_write(9'h003, 4'd4, 32'hB1, 2'b01, "t6_b1");
        req_write = 1'b1; req_address = 9'h005;
        reset_n = 1'b0;
        #1;
        check("t6_rst_wr", {62'h0, avs_write}, 64'h0);
        check("t6_rst_rd", {62'h0, avs_read}, 64'h0);
        check("t6_rst_rvalid", {63'h0, rsp_readdatavalid}, 64'h0);
        check("t6_rst_wait", {63'h0, req_waitrequest}, 64'h1);
        sb.delete();
        @(negedge clk); @(negedge clk);
        req_write = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        bank_beat(1, 32'h42);
        @(negedge clk); @(negedge clk);
        check("t6_late_drop", {63'h0, rsp_readdatavalid}, 64'h0);
        sb.push_back(32'h77); issue_read(9'h003, 4'd1, "t6_new_rd");
        bank_beat(1, 32'h77);
        drain("t6_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
